// File: rtl/riscv_run_controller.sv
// Run controller for the RISCV_Simplified core: drives the core reset sequence,
// bounds the run with a cycle budget and reports how and when the run ended.
module riscv_run_controller #(
  parameter int unsigned RESET_CYCLES = 2,
  parameter int unsigned MAX_CYCLES   = 200,
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned PC_W         = 32,
  parameter int unsigned HALT_REPEAT  = 4,
  parameter logic [31:0] TOHOST_ADDR  = 32'h0000_1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             retire_valid,
  input  logic [PC_W-1:0]  retire_pc,
  input  logic             mem_wr_en,
  input  logic [31:0]      mem_wr_addr,
  input  logic [31:0]      mem_wr_data,
  output logic             core_reset,
  output logic             running,
  output logic             done,
  output logic [2:0]       status,
  output logic [30:0]      exit_code,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instret_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [2:0] STAT_NONE    = 3'd0;
  localparam logic [2:0] STAT_PASS    = 3'd1;
  localparam logic [2:0] STAT_FAIL    = 3'd2;
  localparam logic [2:0] STAT_TIMEOUT = 3'd3;
  localparam logic [2:0] STAT_HALT    = 3'd4;

  localparam int unsigned HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam int unsigned REP_W  = $clog2(HALT_REPEAT + 1);

  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(RESET_CYCLES - 1);
  localparam logic [REP_W-1:0]  REP_HALT  = REP_W'(HALT_REPEAT);
  localparam logic [CNT_W-1:0]  CYC_LIMIT = CNT_W'(MAX_CYCLES);

  state_t            state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [CNT_W-1:0]  cycle_q, cycle_d;
  logic [CNT_W-1:0]  instret_q, instret_d;
  logic [2:0]        status_q, status_d;
  logic [30:0]       exit_q, exit_d;
  logic [PC_W-1:0]   last_pc_q, last_pc_d;
  logic              last_vld_q, last_vld_d;
  logic [REP_W-1:0]  rep_q, rep_d;
  logic              core_reset_q, core_reset_d;
  logic              running_q, running_d;
  logic              done_q, done_d;

  logic [CNT_W-1:0]  cycle_inc_s;
  logic [CNT_W-1:0]  instret_inc_s;
  logic              same_pc_s;
  logic [REP_W-1:0]  rep_next_s;
  logic              tohost_s;
  logic              halt_s;
  logic              timeout_s;

  // Event decode; only acted upon while the core is running.
  always_comb begin
    cycle_inc_s   = cycle_q + {{(CNT_W-1){1'b0}}, 1'b1};
    instret_inc_s = instret_q + {{(CNT_W-1){1'b0}}, retire_valid};
    same_pc_s     = last_vld_q && (retire_pc == last_pc_q);
    if (same_pc_s) begin
      rep_next_s = rep_q + {{(REP_W-1){1'b0}}, 1'b1};
    end else begin
      rep_next_s = {{(REP_W-1){1'b0}}, 1'b1};
    end
    tohost_s  = mem_wr_en && (mem_wr_addr == TOHOST_ADDR) && (mem_wr_data != 32'd0);
    halt_s    = retire_valid && (rep_next_s == REP_HALT);
    timeout_s = (cycle_inc_s == CYC_LIMIT);
  end

  // Next-state and next-value logic for the whole controller.
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    cycle_d    = cycle_q;
    instret_d  = instret_q;
    status_d   = status_q;
    exit_d     = exit_q;
    last_pc_d  = last_pc_q;
    last_vld_d = last_vld_q;
    rep_d      = rep_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d    = ST_HOLD;
          hold_d     = HOLD_LOAD;
          cycle_d    = {CNT_W{1'b0}};
          instret_d  = {CNT_W{1'b0}};
          status_d   = STAT_NONE;
          exit_d     = 31'd0;
          last_pc_d  = {PC_W{1'b0}};
          last_vld_d = 1'b0;
          rep_d      = {REP_W{1'b0}};
        end else begin
          state_d = state_q;
        end
      end
      ST_HOLD: begin
        if (hold_q == {HOLD_W{1'b0}}) begin
          state_d = ST_RUN;
        end else begin
          hold_d = hold_q - {{(HOLD_W-1){1'b0}}, 1'b1};
        end
      end
      ST_RUN: begin
        cycle_d   = cycle_inc_s;
        instret_d = instret_inc_s;
        if (retire_valid) begin
          rep_d      = rep_next_s;
          last_pc_d  = retire_pc;
          last_vld_d = 1'b1;
        end else begin
          rep_d = rep_q;
        end
        // Store result outranks a halt, which outranks running out of budget.
        if (tohost_s) begin
          state_d = ST_DONE;
          if (mem_wr_data == 32'd1) begin
            status_d = STAT_PASS;
          end else begin
            status_d = STAT_FAIL;
            exit_d   = mem_wr_data[31:1];
          end
        end else if (halt_s) begin
          state_d  = ST_DONE;
          status_d = STAT_HALT;
        end else if (timeout_s) begin
          state_d  = ST_DONE;
          status_d = STAT_TIMEOUT;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs follow the state being entered so they are registered with it.
    core_reset_d = (state_d != ST_RUN);
    running_d    = (state_d == ST_RUN);
    done_d       = (state_d == ST_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      hold_q       <= {HOLD_W{1'b0}};
      cycle_q      <= {CNT_W{1'b0}};
      instret_q    <= {CNT_W{1'b0}};
      status_q     <= STAT_NONE;
      exit_q       <= 31'd0;
      last_pc_q    <= {PC_W{1'b0}};
      last_vld_q   <= 1'b0;
      rep_q        <= {REP_W{1'b0}};
      core_reset_q <= 1'b1;
      running_q    <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      cycle_q      <= cycle_d;
      instret_q    <= instret_d;
      status_q     <= status_d;
      exit_q       <= exit_d;
      last_pc_q    <= last_pc_d;
      last_vld_q   <= last_vld_d;
      rep_q        <= rep_d;
      core_reset_q <= core_reset_d;
      running_q    <= running_d;
      done_q       <= done_d;
    end
  end

  assign core_reset    = core_reset_q;
  assign running       = running_q;
  assign done          = done_q;
  assign status        = status_q;
  assign exit_code     = exit_q;
  assign cycle_count   = cycle_q;
  assign instret_count = instret_q;

endmodule

// File: tb/tb_riscv_run_controller.sv
// Self-checking bench for riscv_run_controller: directed table, hand sequences
// and randomized runs against a queue-based reference model.
module tb_riscv_run_controller;

  localparam int unsigned RESET_CYCLES = 2;
  localparam int unsigned MAX_CYCLES   = 200;
  localparam int unsigned CNT_W        = 32;
  localparam int unsigned PC_W         = 32;
  localparam int unsigned HALT_REPEAT  = 4;
  localparam logic [31:0] TOHOST       = 32'h0000_1000;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             retire_valid;
  logic [PC_W-1:0]  retire_pc;
  logic             mem_wr_en;
  logic [31:0]      mem_wr_addr;
  logic [31:0]      mem_wr_data;
  logic             core_reset;
  logic             running;
  logic             done;
  logic [2:0]       status;
  logic [30:0]      exit_code;
  logic [CNT_W-1:0] cycle_count;
  logic [CNT_W-1:0] instret_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  riscv_run_controller #(
    .RESET_CYCLES(RESET_CYCLES), .MAX_CYCLES(MAX_CYCLES), .CNT_W(CNT_W),
    .PC_W(PC_W), .HALT_REPEAT(HALT_REPEAT), .TOHOST_ADDR(TOHOST)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .retire_valid(retire_valid), .retire_pc(retire_pc),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .core_reset(core_reset), .running(running), .done(done), .status(status),
    .exit_code(exit_code), .cycle_count(cycle_count), .instret_count(instret_count)
  );

  typedef struct {
    int          n_ret;
    int          n_idle;
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  exp_status;
    logic [30:0] exp_exit;
    int          exp_instret;
    int          exp_cycles;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Apply one cycle of core activity at a falling edge; return at the next falling edge.
  task automatic cycle(input logic rv, input logic [PC_W-1:0] pc, input logic we,
                       input logic [31:0] addr, input logic [31:0] data);
    retire_valid = rv;
    retire_pc    = pc;
    mem_wr_en    = we;
    mem_wr_addr  = addr;
    mem_wr_data  = data;
    @(negedge clk);
    retire_valid = 1'b0;
    mem_wr_en    = 1'b0;
  endtask

  task automatic start_run();
    int hold_seen;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hold_seen = 0;
    for (int i = 0; i < int'(RESET_CYCLES) + 4 && !running; i++) begin
      if (i == 0) begin
        check("clear_status", status, 3'd0);
        check("clear_exit", exit_code, 31'd0);
        check("clear_cycles", cycle_count, 0);
        check("clear_instret", instret_count, 0);
        check("clear_done", done, 1'b0);
      end
      if (core_reset) hold_seen++;
      @(negedge clk);
    end
    check("hold_len", hold_seen, RESET_CYCLES);
    check("run_entry", running, 1'b1);
    check("run_core_reset", core_reset, 1'b0);
  endtask

  task automatic finish_run();
    int w;
    w = 0;
    while (!done && w < int'(MAX_CYCLES) + 5) begin
      cycle(1'b0, '0, 1'b0, 32'd0, 32'd0);
      w++;
    end
    check("done_reached", done, 1'b1);
    check("done_core_reset", core_reset, 1'b1);
    check("done_running", running, 1'b0);
  endtask

  // Randomized run; expected outcome comes from a retired-PC history queue.
  task automatic random_run(input int mode);
    logic [PC_W-1:0] hist[$];
    int              mcyc, mret, npc, store_odds;
    logic [2:0]      mstat;
    logic [30:0]     mexit;
    bit              ended, halt;
    logic            rv, we;
    logic [PC_W-1:0] pc;
    logic [31:0]     addr, data;
    mcyc = 0; mret = 0; mstat = 3'd0; mexit = 31'd0; ended = 1'b0;
    npc        = (mode == 0) ? 2 : 8;
    store_odds = (mode == 2) ? 8 : 64;
    start_run();
    while (!ended && mcyc < int'(MAX_CYCLES) + 5) begin
      rv   = 1'($urandom_range(0, 1));
      pc   = 32'h40 + 32'(4 * $urandom_range(0, npc - 1));
      we   = ($urandom_range(0, store_odds - 1) == 0);
      addr = ($urandom_range(0, 1) == 1) ? TOHOST : TOHOST + 32'd4;
      case ($urandom_range(0, 2))
        0:       data = 32'd0;
        1:       data = 32'd1;
        default: data = $urandom;
      endcase
      mcyc++;
      if (rv) begin
        hist.push_back(pc);
        mret++;
      end
      halt = 1'b0;
      if (rv && hist.size() >= int'(HALT_REPEAT)) begin
        halt = 1'b1;
        for (int k = 1; k < int'(HALT_REPEAT); k++)
          if (hist[hist.size() - 1 - k] != pc) halt = 1'b0;
      end
      if (we && addr == TOHOST && data != 32'd0) begin
        ended = 1'b1;
        mstat = (data == 32'd1) ? 3'd1 : 3'd2;
        mexit = (data == 32'd1) ? 31'd0 : data[31:1];
      end else if (halt) begin
        ended = 1'b1;
        mstat = 3'd4;
      end else if (mcyc == int'(MAX_CYCLES)) begin
        ended = 1'b1;
        mstat = 3'd3;
      end
      cycle(rv, pc, we, addr, data);
      check("rnd_done", done, ended);
    end
    check("rnd_status", status, mstat);
    check("rnd_exit", exit_code, mexit);
    check("rnd_cycles", cycle_count, mcyc);
    check("rnd_instret", instret_count, mret);
  endtask

  initial begin
    tbl[0] = '{5, 0,   32'h0000_1000, 32'd1,         3'd1, 31'd0,          5, 6};
    tbl[1] = '{0, 0,   32'h0000_1000, 32'd7,         3'd2, 31'd3,          0, 1};
    tbl[2] = '{3, 2,   32'h0000_1000, 32'd0,         3'd3, 31'd0,          3, 200};
    tbl[3] = '{0, 199, 32'h0000_1000, 32'd1,         3'd1, 31'd0,          0, 200};
    tbl[4] = '{2, 0,   32'h0000_1004, 32'd1,         3'd3, 31'd0,          2, 200};
    tbl[5] = '{0, 0,   32'h0000_1000, 32'hFFFF_FFFF, 3'd2, 31'h7FFF_FFFF,  0, 1};
    tbl[6] = '{4, 0,   32'h0000_1000, 32'd2,         3'd2, 31'd1,          4, 5};

    reset = 1'b1; start = 1'b0; retire_valid = 1'b0; retire_pc = '0;
    mem_wr_en = 1'b0; mem_wr_addr = 32'd0; mem_wr_data = 32'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("idle_core_reset", core_reset, 1'b1);
    check("idle_running", running, 1'b0);
    check("idle_done", done, 1'b0);
    check("idle_status", status, 3'd0);
    check("idle_cycles", cycle_count, 0);
    check("idle_instret", instret_count, 0);

    // First RUN edge, then let the budget expire.
    start_run();
    cycle(1'b0, '0, 1'b0, 32'd0, 32'd0);
    check("first_run_cycle", cycle_count, 1);
    check("first_run_running", running, 1'b1);
    finish_run();
    check("timeout_status", status, 3'd3);
    check("timeout_cycles", cycle_count, MAX_CYCLES);

    for (int v = 0; v < 7; v++) begin
      start_run();
      for (int i = 0; i < tbl[v].n_ret; i++)
        cycle(1'b1, 32'h100 + 32'(4 * i), 1'b0, 32'd0, 32'd0);
      for (int i = 0; i < tbl[v].n_idle; i++)
        cycle(1'b0, '0, 1'b0, 32'd0, 32'd0);
      cycle(1'b0, '0, 1'b1, tbl[v].addr, tbl[v].data);
      finish_run();
      check("tbl_status", status, tbl[v].exp_status);
      check("tbl_exit", exit_code, tbl[v].exp_exit);
      check("tbl_instret", instret_count, tbl[v].exp_instret);
      check("tbl_cycles", cycle_count, tbl[v].exp_cycles);
    end

    // Four retirements at one PC halt; DONE then ignores a tohost store.
    start_run();
    repeat (4) cycle(1'b1, 32'h40, 1'b0, 32'd0, 32'd0);
    check("halt_done", done, 1'b1);
    check("halt_status", status, 3'd4);
    check("halt_instret", instret_count, 4);
    check("halt_cycles", cycle_count, 4);
    cycle(1'b1, 32'h40, 1'b1, TOHOST, 32'd1);
    check("done_hold_status", status, 3'd4);
    check("done_hold_instret", instret_count, 4);
    check("done_hold_cycles", cycle_count, 4);

    // A different PC breaks the repeat streak.
    start_run();
    repeat (3) cycle(1'b1, 32'h40, 1'b0, 32'd0, 32'd0);
    cycle(1'b1, 32'h44, 1'b0, 32'd0, 32'd0);
    repeat (3) cycle(1'b1, 32'h40, 1'b0, 32'd0, 32'd0);
    check("streak_broken", done, 1'b0);
    cycle(1'b1, 32'h40, 1'b0, 32'd0, 32'd0);
    check("streak_halt", status, 3'd4);
    check("streak_instret", instret_count, 8);

    for (int r = 0; r < 30; r++) random_run(r % 3);

    // Asynchronous reset between clock edges in the middle of a run.
    start_run();
    repeat (3) cycle(1'b1, 32'h200, 1'b0, 32'd0, 32'd0);
    #2;
    reset = 1'b1;
    #1;
    check("async_core_reset", core_reset, 1'b1);
    check("async_running", running, 1'b0);
    check("async_cycles", cycle_count, 0);
    check("async_instret", instret_count, 0);
    #1;
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("post_reset_running", running, 1'b0);
    check("post_reset_core_reset", core_reset, 1'b1);
    check("post_reset_done", done, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
